// File: rtl/axi_wr_channel_router.sv
// AXI4 write slave steering each W beat to one of NUM_CH FIFOs by awaddr[7:4]; push is combinational from the W handshake.
// wready follows ch_full of the selected channel (clear/error bursts drain freely); `WSTRB_CHECK_EN drains partial-strobe beats with SLVERR.
module axi_wr_channel_router #(
   parameter int NUM_CH = 2,
   parameter int DATA_W = 32,
   parameter int ID_W   = 4,
   parameter int IDX_W  = 10
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ID_W-1:0]       axs_awid,
   input  logic [31:0]           axs_awaddr,
   input  logic [7:0]            axs_awlen,
   input  logic                  axs_awvalid,
   output logic                  axs_awready,
   input  logic [DATA_W-1:0]     axs_wdata,
   input  logic [DATA_W/8-1:0]   axs_wstrb,
   input  logic                  axs_wlast,
   input  logic                  axs_wvalid,
   output logic                  axs_wready,
   output logic [ID_W-1:0]       axs_bid,
   output logic [1:0]            axs_bresp,
   output logic                  axs_bvalid,
   input  logic                  axs_bready,
   input  logic [NUM_CH-1:0]     ch_full,
   output logic [NUM_CH-1:0]     ch_push,
   output logic [NUM_CH-1:0]     ch_last,
   output logic [NUM_CH-1:0]     ch_clr,
   output logic [DATA_W-1:0]     wdata_o,
   output logic [DATA_W/8-1:0]   wstrb_o,
   output logic [IDX_W-1:0]      index_o
);
   localparam int STRB_W = DATA_W / 8;
   localparam logic [4:0] NUM_CH_L = 5'(NUM_CH);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_DATA = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   localparam logic [1:0] OP_DATA = 2'd0;
   localparam logic [1:0] OP_REC  = 2'd1;
   localparam logic [1:0] OP_CLR  = 2'd2;
   localparam logic [1:0] OP_ERR  = 2'd3;

   logic [1:0]        state_q, state_d;
   logic [ID_W-1:0]   id_q;
   logic [3:0]        sel_q;
   logic [1:0]        op_q;
   logic [7:0]        len_q;
   logic [7:0]        cnt_q;
   logic              err_q;
   logic [NUM_CH-1:0] clr_q;
   logic [IDX_W-1:0]  idx_q [NUM_CH];

   logic [3:0]        aw_sel;
   logic [3:0]        aw_op;
   logic              aw_dec_err;
   logic [1:0]        aw_opc;
   logic              aw_hs;
   logic [NUM_CH-1:0] aw_clr_oh;
   logic [NUM_CH-1:0] sel_oh;
   logic [IDX_W-1:0]  idx_sel;
   logic              full_sel;
   logic              is_data;
   logic              in_data;
   logic              accept;
   logic              final_beat;
   logic              strb_bad;
   logic              push;
   logic              last_push;
   logic              beat_err;
   logic              unused_addr_hi;

   assign unused_addr_hi = ^axs_awaddr[31:8];

   assign aw_sel     = axs_awaddr[7:4];
   assign aw_op      = axs_awaddr[3:0];
   assign aw_dec_err = (aw_op > 4'd2) || ({1'b0, aw_sel} >= NUM_CH_L);
   assign aw_opc     = aw_dec_err ? OP_ERR : aw_op[1:0];

   // Every output is forced low while reset is held, so a mid-burst reset is silent at once.
   assign axs_awready = (state_q == S_IDLE) && !reset;
   assign aw_hs       = axs_awready && axs_awvalid;

   always_comb begin
      sel_oh    = '0;
      aw_clr_oh = '0;
      idx_sel   = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         sel_oh[c]    = (sel_q == 4'(c));
         aw_clr_oh[c] = aw_hs && (aw_opc == OP_CLR) && (aw_sel == 4'(c));
         if (sel_q == 4'(c)) begin
            idx_sel = idx_q[c];
         end
      end
   end

   assign full_sel   = |(ch_full & sel_oh);
   assign is_data    = (op_q == OP_DATA) || (op_q == OP_REC);
   assign in_data    = (state_q == S_DATA) && !reset;
   assign axs_wready = in_data && (is_data ? !full_sel : 1'b1);
   assign accept     = axs_wready && axs_wvalid;
   assign final_beat = (cnt_q == len_q);

`ifdef WSTRB_CHECK_EN
   assign strb_bad = is_data && (axs_wstrb != {STRB_W{1'b1}});
`else
   assign strb_bad = 1'b0;
`endif

   assign push      = accept && is_data && !strb_bad;
   assign last_push = push && (op_q == OP_REC) && final_beat;
   // awlen alone ends the burst; a wrong wlast only poisons the response.
   assign beat_err  = accept && ((axs_wlast != final_beat) || strb_bad);

   assign ch_push = push      ? sel_oh    : '0;
   assign ch_last = last_push ? sel_oh    : '0;
   assign wdata_o = push      ? axs_wdata : '0;
   assign wstrb_o = push      ? axs_wstrb : '0;
   assign index_o = push      ? idx_sel   : '0;
   assign ch_clr  = reset     ? '0        : clr_q;

   assign axs_bvalid = (state_q == S_RESP) && !reset;
   assign axs_bid    = axs_bvalid ? id_q : '0;
   assign axs_bresp  = axs_bvalid ? {err_q, 1'b0} : 2'b00;

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (aw_hs) state_d = S_DATA;
         S_DATA:  if (accept && final_beat) state_d = S_RESP;
         S_RESP:  if (axs_bready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         id_q    <= '0;
         sel_q   <= '0;
         op_q    <= OP_DATA;
         len_q   <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         clr_q   <= '0;
         for (int c = 0; c < NUM_CH; c++) begin
            idx_q[c] <= '0;
         end
      end else begin
         state_q <= state_d;
         clr_q   <= aw_clr_oh;
         if (aw_hs) begin
            id_q  <= axs_awid;
            sel_q <= aw_sel;
            op_q  <= aw_opc;
            len_q <= axs_awlen;
            cnt_q <= '0;
            err_q <= aw_dec_err;
         end
         if (accept) begin
            cnt_q <= cnt_q + 8'd1;
            if (beat_err) begin
               err_q <= 1'b1;
            end
         end
         for (int c = 0; c < NUM_CH; c++) begin
            if (aw_clr_oh[c]) begin
               idx_q[c] <= '0;
            end else if (ch_push[c]) begin
               idx_q[c] <= ch_last[c] ? '0 : idx_q[c] + IDX_W'(1);
            end
         end
      end
   end
endmodule

// File: tb/tb_axi_wr_channel_router.sv
// Randomised bench for axi_wr_channel_router against a transaction-level model of the routing rules.
module tb_axi_wr_channel_router;
   localparam int NUM_CH = 2;
   localparam int DATA_W = 32;
   localparam int ID_W   = 4;
   localparam int IDX_W  = 10;
   localparam int PE_W   = 2 * NUM_CH + IDX_W + DATA_W / 8 + DATA_W;

   typedef logic [PE_W-1:0] pe_t;

   logic                clk = 1'b0;
   logic                reset;
   logic [ID_W-1:0]     axs_awid;
   logic [31:0]         axs_awaddr;
   logic [7:0]          axs_awlen;
   logic                axs_awvalid;
   logic                axs_awready;
   logic [DATA_W-1:0]   axs_wdata;
   logic [DATA_W/8-1:0] axs_wstrb;
   logic                axs_wlast;
   logic                axs_wvalid;
   logic                axs_wready;
   logic [ID_W-1:0]     axs_bid;
   logic [1:0]          axs_bresp;
   logic                axs_bvalid;
   logic                axs_bready;
   logic [NUM_CH-1:0]   ch_full;
   logic [NUM_CH-1:0]   ch_push;
   logic [NUM_CH-1:0]   ch_last;
   logic [NUM_CH-1:0]   ch_clr;
   logic [DATA_W-1:0]   wdata_o;
   logic [DATA_W/8-1:0] wstrb_o;
   logic [IDX_W-1:0]    index_o;

   int checks = 0;
   int errors = 0;

   logic [DATA_W-1:0]   b_dat  [256];
   logic [DATA_W/8-1:0] b_strb [256];
   logic                b_last [256];

   pe_t        exp_q[$];
   pe_t        obs_q[$];
   logic [1:0] exp_bresp;
   int         midx    [NUM_CH];
   int         exp_clr [NUM_CH];
   int         obs_clr [NUM_CH];
   logic [ID_W-1:0] obs_bid;
   logic [1:0]      obs_bresp;
   int         viol;
   bit         timeout;
   bit         got_resp;

   axi_wr_channel_router #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .ID_W(ID_W), .IDX_W(IDX_W)) dut (
      .clk(clk), .reset(reset),
      .axs_awid(axs_awid), .axs_awaddr(axs_awaddr), .axs_awlen(axs_awlen),
      .axs_awvalid(axs_awvalid), .axs_awready(axs_awready),
      .axs_wdata(axs_wdata), .axs_wstrb(axs_wstrb), .axs_wlast(axs_wlast),
      .axs_wvalid(axs_wvalid), .axs_wready(axs_wready),
      .axs_bid(axs_bid), .axs_bresp(axs_bresp), .axs_bvalid(axs_bvalid), .axs_bready(axs_bready),
      .ch_full(ch_full), .ch_push(ch_push), .ch_last(ch_last), .ch_clr(ch_clr),
      .wdata_o(wdata_o), .wstrb_o(wstrb_o), .index_o(index_o)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish, checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end

   // Beats for the next burst; bad >= 0 flips wlast on that beat.
   task automatic gen_beats(input int len, input int bad, input int strb_pct);
      for (int i = 0; i <= len; i++) begin
         b_dat[i]  = $urandom;
         b_strb[i] = ($urandom_range(99) < strb_pct) ? 4'hF : 4'($urandom);
         b_last[i] = (i == len) ^ (i == bad);
      end
   endtask

   // Transaction model: what a burst to addr must produce, straight from the address map rules.
   task automatic model_txn(input logic [31:0] addr, input int len);
      int ch  = int'(addr[7:4]);
      int op  = int'(addr[3:0]);
      bit dec = (op > 2) || (ch >= NUM_CH);
      bit err = dec;
      bit pushit;
      bit fin;
      logic [NUM_CH-1:0] v;
      logic [NUM_CH-1:0] lv;
      exp_q.delete();
      foreach (exp_clr[c]) exp_clr[c] = 0;
      if (!dec && op == 2) begin
         exp_clr[ch] = 1;
         midx[ch]    = 0;
      end
      for (int i = 0; i <= len; i++) begin
         fin    = (i == len);
         pushit = !dec && (op < 2);
         if (b_last[i] != fin) err = 1;
`ifdef WSTRB_CHECK_EN
         if (pushit && b_strb[i] != 4'hF) begin
            err    = 1;
            pushit = 0;
         end
`endif
         if (pushit) begin
            v      = '0;
            v[ch]  = 1'b1;
            lv     = (op == 1 && fin) ? v : '0;
            exp_q.push_back({v, lv, IDX_W'(midx[ch]), b_strb[i], b_dat[i]});
            midx[ch] = (op == 1 && fin) ? 0 : (midx[ch] + 1) % (1 << IDX_W);
         end
      end
      exp_bresp = err ? 2'b10 : 2'b00;
   endtask

   // Drives one AW + W burst + B handshake and records everything the DUT emits.
   // full_pct < 0 holds ch_full[0] high for burst cycles 1..4.
   task automatic run_txn(input logic [ID_W-1:0] id, input logic [31:0] addr, input int len,
                          input int full_pct, input int vld_pct);
      int  sel = int'(addr[7:4]);
      bit  dop = (addr[3:0] < 4'd2) && (sel < NUM_CH);
      bit  hs  = 0;
      int  n   = 0;
      int  beat = 0;
      obs_q.delete();
      foreach (obs_clr[c]) obs_clr[c] = 0;
      viol = 0; timeout = 0; got_resp = 0; obs_bid = '0; obs_bresp = '0;
      axs_awvalid = 1'b1; axs_awid = id; axs_awaddr = addr; axs_awlen = 8'(len);
      while (!hs && n < 50) begin
         @(negedge clk);
         hs = axs_awready;
         @(posedge clk); #1;
         n++;
      end
      axs_awvalid = 1'b0;
      if (!hs) timeout = 1;
      n = 0;
      while (!timeout && beat <= len && n < 4000) begin
         axs_wvalid = ($urandom_range(99) < vld_pct);
         axs_wdata  = b_dat[beat];
         axs_wstrb  = b_strb[beat];
         axs_wlast  = b_last[beat];
         for (int c = 0; c < NUM_CH; c++) begin
            if (full_pct < 0) ch_full[c] = (c == 0) && (n >= 1) && (n <= 4);
            else              ch_full[c] = ($urandom_range(99) < full_pct);
         end
         @(negedge clk);
         foreach (obs_clr[c]) if (ch_clr[c]) obs_clr[c]++;
         if (ch_push != '0) obs_q.push_back({ch_push, ch_last, index_o, wstrb_o, wdata_o});
         if (ch_push != '0 && !(axs_wvalid && axs_wready)) viol++;
         if (dop && axs_wready && ch_full[sel]) viol++;
         if (axs_wvalid && axs_wready) beat++;
         @(posedge clk); #1;
         n++;
      end
      if (beat <= len) timeout = 1;
      axs_wvalid = 1'b0;
      ch_full    = '0;
      n = 0;
      while (!timeout && !got_resp && n < 50) begin
         @(negedge clk);
         foreach (obs_clr[c]) if (ch_clr[c]) obs_clr[c]++;
         if (ch_push != '0) viol++;
         if (axs_bvalid) begin
            got_resp   = 1;
            obs_bid    = axs_bid;
            obs_bresp  = axs_bresp;
            if (axs_awready) viol++;
            axs_bready = 1'b1;
         end
         @(posedge clk); #1;
         axs_bready = 1'b0;
         n++;
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({axs_awready, axs_wready, axs_bvalid, axs_bid, axs_bresp} !== '0) begin
         errors++;
         $display("FAIL reset_axi got aw/w/b=%b%b%b bid=%h bresp=%b want all 0", axs_awready, axs_wready, axs_bvalid, axs_bid, axs_bresp);
      end
      checks++;
      if ({ch_push, ch_last, ch_clr, wdata_o, wstrb_o, index_o} !== '0) begin
         errors++;
         $display("FAIL reset_ch got push=%b last=%b clr=%b wdata=%h wstrb=%h idx=%0d want all 0", ch_push, ch_last, ch_clr, wdata_o, wstrb_o, index_o);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (axs_awready !== 1'b1 || axs_bvalid !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle got awready=%b bvalid=%b want 1 0", axs_awready, axs_bvalid);
      end
      foreach (midx[c]) midx[c] = 0;
      @(posedge clk); #1;
   endtask

   task automatic test_single;
      b_dat[0] = 32'hDEADBEEF; b_strb[0] = 4'hF; b_last[0] = 1'b1;
      model_txn(32'h10, 0);
      run_txn(4'h5, 32'h10, 0, 0, 100);
      checks++;
      if (timeout || !got_resp || obs_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL single_count got %0d pushes resp=%0d timeout=%0d want %0d pushes", obs_q.size(), got_resp, timeout, exp_q.size());
      end else foreach (exp_q[i]) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL single_push[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
         end
      end
      checks++;
      if (obs_bresp !== 2'b00 || obs_bid !== 4'h5) begin
         errors++;
         $display("FAIL single_resp got bid=%h bresp=%b want bid=5 bresp=00", obs_bid, obs_bresp);
      end
   endtask

   task automatic test_burst_record;
      gen_beats(3, -1, 100);
      model_txn(32'h01, 3);
      run_txn(4'h3, 32'h01, 3, 0, 100);
      checks++;
      if (timeout || obs_q.size() != 4 || exp_q.size() != 4) begin
         errors++;
         $display("FAIL burst_count got %0d pushes timeout=%0d want 4", obs_q.size(), timeout);
      end else foreach (exp_q[i]) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL burst_push[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
         end
      end
      checks++;
      if (obs_bresp !== exp_bresp || obs_bid !== 4'h3) begin
         errors++;
         $display("FAIL burst_resp got bid=%h bresp=%b want bid=3 bresp=%b", obs_bid, obs_bresp, exp_bresp);
      end
      gen_beats(0, -1, 100);
      model_txn(32'h00, 0);
      run_txn(4'h4, 32'h00, 0, 0, 100);
      checks++;
      if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
         errors++;
         $display("FAIL burst_next_index got %0d pushes idx=%0d want 1 push idx=0", obs_q.size(), index_o);
      end
   endtask

   task automatic test_backpressure;
      gen_beats(3, -1, 100);
      model_txn(32'h00, 3);
      run_txn(4'h6, 32'h00, 3, -1, 100);
      checks++;
      if (viol != 0 || timeout) begin
         errors++;
         $display("FAIL backpressure_ready got %0d wready-while-full/stray pushes timeout=%0d want 0", viol, timeout);
      end
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL backpressure_count got %0d pushes want %0d", obs_q.size(), exp_q.size());
      end else foreach (exp_q[i]) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL backpressure_push[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_decode_error;
      logic [31:0] addrs [2];
      addrs[0] = 32'h30;
      addrs[1] = 32'h07;
      foreach (addrs[k]) begin
         gen_beats(1, -1, 100);
         model_txn(addrs[k], 1);
         run_txn(4'h9, addrs[k], 1, 50, 100);
         checks++;
         if (timeout || obs_q.size() != 0) begin
            errors++;
            $display("FAIL decode_drain addr=%h got %0d pushes timeout=%0d want 0 pushes", addrs[k], obs_q.size(), timeout);
         end
         checks++;
         if (obs_bresp !== exp_bresp || obs_bid !== 4'h9) begin
            errors++;
            $display("FAIL decode_resp addr=%h got bid=%h bresp=%b want bid=9 bresp=%b", addrs[k], obs_bid, obs_bresp, exp_bresp);
         end
      end
   endtask

   task automatic test_wlast_mismatch;
      gen_beats(2, 0, 100);
      model_txn(32'h10, 2);
      run_txn(4'hA, 32'h10, 2, 0, 100);
      checks++;
      if (timeout || obs_q.size() != exp_q.size() || obs_bresp !== exp_bresp) begin
         errors++;
         $display("FAIL wlast_early got %0d pushes bresp=%b want %0d pushes bresp=%b", obs_q.size(), obs_bresp, exp_q.size(), exp_bresp);
      end
      gen_beats(1, 1, 100);
      model_txn(32'h11, 1);
      run_txn(4'hB, 32'h11, 1, 0, 100);
      checks++;
      if (timeout || obs_q.size() != exp_q.size() || obs_bresp !== exp_bresp) begin
         errors++;
         $display("FAIL wlast_missing got %0d pushes bresp=%b want %0d pushes bresp=%b", obs_q.size(), obs_bresp, exp_q.size(), exp_bresp);
      end
   endtask

   task automatic test_clear;
      gen_beats(4, -1, 100);
      model_txn(32'h00, 4);
      run_txn(4'h1, 32'h00, 4, 0, 100);
      gen_beats(0, -1, 100);
      model_txn(32'h02, 0);
      run_txn(4'h2, 32'h02, 0, 30, 100);
      foreach (exp_clr[c]) begin
         checks++;
         if (obs_clr[c] != exp_clr[c]) begin
            errors++;
            $display("FAIL clear_pulse ch%0d got %0d pulses want %0d", c, obs_clr[c], exp_clr[c]);
         end
      end
      checks++;
      if (obs_q.size() != 0 || obs_bresp !== exp_bresp) begin
         errors++;
         $display("FAIL clear_resp got %0d pushes bresp=%b want 0 pushes bresp=%b", obs_q.size(), obs_bresp, exp_bresp);
      end
      gen_beats(0, -1, 100);
      model_txn(32'h00, 0);
      run_txn(4'h3, 32'h00, 0, 0, 100);
      checks++;
      if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
         errors++;
         $display("FAIL clear_next_index got %0d pushes first=%h want %h", obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : pe_t'(0), exp_q[0]);
      end
   endtask

   task automatic test_random;
      logic [31:0] pool [9];
      logic [31:0] a;
      logic [ID_W-1:0] id;
      int len;
      pool[0] = 32'h00; pool[1] = 32'h01; pool[2] = 32'h02; pool[3] = 32'h10; pool[4] = 32'h11;
      pool[5] = 32'h12; pool[6] = 32'h20; pool[7] = 32'h05; pool[8] = 32'h13;
      for (int t = 0; t < 40; t++) begin
         a   = pool[$urandom_range(8)];
         len = $urandom_range(7);
         id  = ID_W'($urandom);
         gen_beats(len, ($urandom_range(4) == 0) ? int'($urandom_range(len)) : -1, 80);
         model_txn(a, len);
         run_txn(id, a, len, $urandom_range(60), $urandom_range(60, 100));
         checks++;
         if (timeout || !got_resp || viol != 0 || obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL rand%0d addr=%h len=%0d got %0d pushes viol=%0d timeout=%0d want %0d pushes", t, a, len, obs_q.size(), viol, timeout, exp_q.size());
         end else foreach (exp_q[i]) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
               errors++;
               $display("FAIL rand%0d_push[%0d] got %h want %h", t, i, obs_q[i], exp_q[i]);
            end
         end
         checks++;
         if (obs_bresp !== exp_bresp || obs_bid !== id || obs_clr[0] != exp_clr[0] || obs_clr[1] != exp_clr[1]) begin
            errors++;
            $display("FAIL rand%0d_resp got bid=%h bresp=%b clr=%0d/%0d want bid=%h bresp=%b clr=%0d/%0d", t, obs_bid, obs_bresp, obs_clr[0], obs_clr[1], id, exp_bresp, exp_clr[0], exp_clr[1]);
         end
      end
   endtask

   task automatic test_reset_mid_burst;
      int n = 0;
      int beat = 0;
      bit hs = 0;
      bit saw_b = 0;
      gen_beats(3, -1, 100);
      axs_awvalid = 1'b1; axs_awid = 4'h7; axs_awaddr = 32'h01; axs_awlen = 8'd3;
      while (!hs && n < 50) begin
         @(negedge clk);
         hs = axs_awready;
         @(posedge clk); #1;
         n++;
      end
      axs_awvalid = 1'b0;
      n = 0;
      while (beat < 2 && n < 50) begin
         axs_wvalid = 1'b1; axs_wdata = b_dat[beat]; axs_wstrb = b_strb[beat]; axs_wlast = b_last[beat];
         @(negedge clk);
         if (axs_wready) beat++;
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (beat != 2) begin
         errors++;
         $display("FAIL midreset_setup got %0d beats accepted want 2", beat);
      end
      reset = 1'b1;
      axs_wdata = b_dat[2]; axs_wlast = b_last[2];
      @(negedge clk);
      checks++;
      if ({axs_awready, axs_wready, axs_bvalid, axs_bid, axs_bresp, ch_push, ch_last, ch_clr, wdata_o, wstrb_o, index_o} !== '0) begin
         errors++;
         $display("FAIL midreset_outputs got awready=%b wready=%b bvalid=%b push=%b idx=%0d want all 0", axs_awready, axs_wready, axs_bvalid, ch_push, index_o);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      axs_wvalid = 1'b0;
      foreach (midx[c]) midx[c] = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (axs_bvalid) saw_b = 1;
         if (k == 0) begin
            checks++;
            if (axs_awready !== 1'b1) begin
               errors++;
               $display("FAIL midreset_idle got awready=%b want 1", axs_awready);
            end
         end
         @(posedge clk); #1;
      end
      checks++;
      if (saw_b) begin
         errors++;
         $display("FAIL midreset_no_resp got bvalid=1 want no response");
      end
      gen_beats(0, -1, 100);
      model_txn(32'h01, 0);
      run_txn(4'h8, 32'h01, 0, 0, 100);
      checks++;
      if (obs_q.size() != 1 || obs_q[0] !== exp_q[0] || obs_bid !== 4'h8) begin
         errors++;
         $display("FAIL midreset_after got %0d pushes bid=%h want 1 push %h bid=8", obs_q.size(), obs_bid, exp_q[0]);
      end
   endtask

   initial begin
      reset = 1'b1;
      axs_awid = '0; axs_awaddr = '0; axs_awlen = '0; axs_awvalid = 1'b0;
      axs_wdata = '0; axs_wstrb = '0; axs_wlast = 1'b0; axs_wvalid = 1'b0;
      axs_bready = 1'b0; ch_full = '0;
      test_reset;
      test_single;
      test_burst_record;
      test_backpressure;
      test_decode_error;
      test_wlast_mismatch;
      test_clear;
      test_random;
      test_reset_mid_burst;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/axi_wr_channel_router.md
Name: axi_wr_channel_router

Overview:
- AXI4 write slave that accepts single or burst writes and steers each data beat into one of NUM_CH datapath input FIFOs, selected by address.
- Generalises the fixed two-channel write FSM. Adds:
  - parameterised channel count and widths
  - burst (awlen) support with per-beat push
  - per-channel beat index counters
  - a clear operation
  - error responses
- Sits between the AXI4 interconnect and the varint / raw-data input FIFOs.

Parameters:
- NUM_CH, 2: number of downstream channels (1..16).
- DATA_W, 32: wdata width; wstrb width is DATA_W/8.
- ID_W, 4: AXI ID width.
- IDX_W, 10: width of the per-channel beat index counter.

Ports:
- clk  in  1  clock.
- reset  in  1  reset.
- axs_awid  in  ID_W  write address ID.
- axs_awaddr  in  32  write address.
- axs_awlen  in  8  burst length minus 1.
- axs_awvalid  in  1  address valid.
- axs_awready  out  1  address ready.
- axs_wdata  in  DATA_W  write data.
- axs_wstrb  in  DATA_W/8  byte strobes.
- axs_wlast  in  1  last beat of burst.
- axs_wvalid  in  1  data valid.
- axs_wready  out  1  data ready.
- axs_bid  out  ID_W  response ID.
- axs_bresp  out  2  response: 00 OKAY, 10 SLVERR.
- axs_bvalid  out  1  response valid.
- axs_bready  in  1  response ready.
- ch_full  in  NUM_CH  per-channel FIFO full.
- ch_push  out  NUM_CH  one-hot push strobe.
- ch_last  out  NUM_CH  qualifies ch_push: beat ends a record.
- ch_clr  out  NUM_CH  one-cycle FIFO/index clear pulse.
- wdata_o  out  DATA_W  data for pushed beat.
- wstrb_o  out  DATA_W/8  strobes for pushed beat.
- index_o  out  IDX_W  beat index of pushed beat within the channel.

Behaviour:
- Reset: reset, synchronous, active-high; clock clk.
  - All outputs 0.
  - State IDLE.
  - All index counters 0.
  - Reset mid-burst abandons the transaction; no response is issued.
- Address decode:
  - Channel: sel = awaddr[7:4].
  - Operation from awaddr[3:0]:
    - 0x0: normal data.
    - 0x1: record data; the final beat is flagged last.
    - 0x2: clear.
    - Other: decode error.
  - sel >= NUM_CH is also a decode error.
- States:
  - IDLE: awready=1. On awvalid, latch awid, sel, op and awlen; go to DATA. For clear, pulse ch_clr[sel] for 1 cycle on entry.
  - DATA: wready = (op is data AND !ch_full[sel]) OR op is error/clear.
    - Beat accepted when wvalid && wready.
    - Data op: ch_push[sel]=1 in the same cycle (combinational from the handshake). wdata_o, wstrb_o and index_o are driven from the current beat.
    - Clear/error ops drain beats without pushing.
    - Beat counter increments per accepted beat. The beat where count==awlen is final; go to RESP.
  - RESP: bvalid=1, bid=latched awid, bresp=latched error flag. On bready, return to IDLE (not directly back-to-back; awready rises the following cycle).
- Full handling: wready deasserts while ch_full[sel]=1; the beat is held by the master and no push occurs. Full may toggle mid-burst with no data loss.
- ch_last[sel]=1 only with the final push of an op-0x1 burst.
- Index counter[sel]:
  - Increments per push.
  - Wraps at 2^IDX_W silently.
  - Resets to 0 after an op-0x1 final push and on clear.
  - Clear and push on the same channel in the same cycle is impossible by construction.
- Error flag set on any of:
  - decode error
  - wlast mismatch: wlast=1 before the final beat, or wlast=0 on the final beat
  - WSTRB_CHECK_EN violation (see Optional Feature)
- awlen is the sole burst terminator; a mismatched wlast does not terminate the burst early.

Optional Feature:
- Macro: WSTRB_CHECK_EN.
- Defined: a data beat with wstrb != all-ones is accepted but not pushed, and the error flag is set (SLVERR).
- Undefined: wstrb passes through to wstrb_o unchecked; only decode errors and wlast mismatch produce SLVERR.

Test Plan:
- Single write: addr 0x10, awlen 0, data 0xDEADBEEF, ch_full=0 -> ch_push=2'b10 for 1 cycle, index_o=0, bresp=00, bid echoes 4'h5.
- Burst record: addr 0x01, awlen 3, ch_full[0]=0 -> 4 pushes on ch0 with index 0..3, ch_last only on beat 3; a following write starts at index 0.
- Backpressure: ch_full[0]=1 for cycles 2-5 of a 4-beat burst -> wready=0 while full, exactly 4 pushes, no duplicates or drops.
- Decode error: addr 0x30 with NUM_CH=2, awlen 1 -> 2 beats drained, no ch_push, bresp=10.
- Clear: addr 0x02 after 5 pushes -> ch_clr[0] pulses once; the next push shows index_o=0.
- Reset asserted mid-burst at beat 2 -> all outputs 0 next cycle, awready=1 in IDLE, no bvalid.
